// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
//   mem_state_t : responder FSM states
//   WORD_BYTES  : bytes per storage word
//   MAX_LATENCY : largest wait-state count the 4-bit counter can hold
//   addr_err()  : true when a byte address is misaligned or beyond the storage
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned MAX_LATENCY = 15;

  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_log2);
    logic [31:0] align_mask;
    logic [31:0] hi_bits;
    align_mask = 32'(WORD_BYTES - 1);
    hi_bits    = addr >> (depth_log2 + 2);
    return ((addr & align_mask) != 32'h0) || (hi_bits != 32'h0);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter used to time wait states.
//   Clk, Reset : clock, asynchronous active-high reset
//   load       : load 'value' this edge (takes priority over decrement)
//   value      : load value
//   zero       : count is 0
//   one        : count is 1 (the next decrement reaches zero)
// The counter decrements on every edge while non-zero and not loading.
module mem_wait_counter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [3:0] value,
  output logic       zero,
  output logic       one
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 4'd0);
  assign one  = (count_q == 4'd1);

endmodule

// File: rtl/mem_responder.sv
// Handshaked single-word memory target with configurable wait states.
//   Clk, Reset : clock, asynchronous active-high reset
//   Req        : request valid, sampled only in IDLE
//   Wr         : 1 = write, 0 = read (sampled with Req)
//   Address    : word-aligned byte address (sampled with Req)
//   WriteData  : write data (sampled with Req)
//   DataOut    : read data, updated on successful reads, forced to 0 on errors
//   Ready      : one-cycle response pulse
//   Busy       : transaction in flight (WAIT or RESP)
//   AddrErr    : qualifies Ready; the transaction was rejected
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] DataOut,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;
  localparam logic [3:0] LatVal = (LATENCY > MAX_LATENCY) ? 4'(MAX_LATENCY) : 4'(LATENCY);

  mem_state_t state_q, state_d;

  logic [31:0] addr_q, wdata_q, data_q, data_d;
  logic        wr_q, err_q, err_d;

  logic        accept;
  logic        enter_resp;
  logic        cnt_zero, cnt_one;

  // Transaction view: with zero latency RESP is entered on the accepting edge, before the
  // request registers hold anything, so the live inputs stand in for the latched ones.
  logic [31:0]           txn_addr, txn_wdata;
  logic                  txn_wr, txn_err;
  logic [DEPTH_LOG2-1:0] txn_idx;
  logic                  mem_we;

  logic [31:0] mem_q [Words];

  mem_wait_counter u_wait_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (accept),
    .value (LatVal),
    .zero  (cnt_zero),
    .one   (cnt_one)
  );

  assign accept = (state_q == IDLE) && Req;

  always_comb begin
    state_d    = state_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Req) begin
          if (LatVal == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Leave on the edge where the counter steps 1 -> 0.
        if (cnt_one || cnt_zero) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    if (state_q == IDLE) begin
      txn_addr  = Address;
      txn_wr    = Wr;
      txn_wdata = WriteData;
    end else begin
      txn_addr  = addr_q;
      txn_wr    = wr_q;
      txn_wdata = wdata_q;
    end
    txn_err = addr_err(txn_addr, DEPTH_LOG2);
    txn_idx = txn_addr[DEPTH_LOG2+1:2];
    mem_we  = enter_resp && txn_wr && !txn_err;
  end

  always_comb begin
    data_d = data_q;
    err_d  = err_q;
    if (enter_resp) begin
      err_d = txn_err;
      if (txn_err) begin
        data_d = 32'h0;
      end else if (!txn_wr) begin
        data_d = mem_q[txn_idx];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wr_q    <= 1'b0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= Address;
        wr_q    <= Wr;
        wdata_q <= WriteData;
      end
    end
  end

  // Storage is never cleared; Reset only blocks a write that would race the reset.
  always_ff @(posedge Clk) begin
    if (mem_we && !Reset) begin
      mem_q[txn_idx] <= txn_wdata;
    end
  end

  assign DataOut = data_q;
  assign Ready   = (state_q == RESP);
  assign Busy    = (state_q != IDLE);
  assign AddrErr = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        Clk;
  logic        Reset2, Reset0;
  logic        Req2, Wr2, Req0, Wr0;
  logic [31:0] Address2, WriteData2, Address0, WriteData0;
  logic [31:0] DataOut2, DataOut0;
  logic        Ready2, Busy2, AddrErr2, Ready0, Busy0, AddrErr0;

  int checks = 0;
  int errors = 0;

  mem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_dut2 (
    .Clk       (Clk),
    .Reset     (Reset2),
    .Req       (Req2),
    .Wr        (Wr2),
    .Address   (Address2),
    .WriteData (WriteData2),
    .DataOut   (DataOut2),
    .Ready     (Ready2),
    .Busy      (Busy2),
    .AddrErr   (AddrErr2)
  );

  mem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) u_dut0 (
    .Clk       (Clk),
    .Reset     (Reset0),
    .Req       (Req0),
    .Wr        (Wr0),
    .Address   (Address0),
    .WriteData (WriteData0),
    .DataOut   (DataOut0),
    .Ready     (Ready0),
    .Busy      (Busy0),
    .AddrErr   (AddrErr0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one request on the selected DUT (1 = LATENCY 0, 0 = LATENCY 2) and follow it to Ready.
  task automatic run_txn(input bit sel, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int busy_n,
                         output logic err, output logic [31:0] data);
    if (sel) begin
      Req0 = 1'b1; Wr0 = wr; Address0 = addr; WriteData0 = wdata;
    end else begin
      Req2 = 1'b1; Wr2 = wr; Address2 = addr; WriteData2 = wdata;
    end
    @(posedge Clk); #1;
    Req0 = 1'b0;
    Req2 = 1'b0;
    lat    = 0;
    busy_n = 0;
    err    = 1'b0;
    data   = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      if (sel ? Busy0 : Busy2) busy_n++;
      if (sel ? Ready0 : Ready2) begin
        lat  = c;
        err  = sel ? AddrErr0 : AddrErr2;
        data = sel ? DataOut0 : DataOut2;
        break;
      end
      @(posedge Clk); #1;
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=none expected=Ready within 20 cycles");
    end else begin
      @(posedge Clk); #1;
      check("idle_after_resp", {31'h0, sel ? Busy0 : Busy2}, 32'h0);
    end
  endtask

  int          lat, busy_n;
  logic        err;
  logic [31:0] data;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0012, 32'h0000_0001, 1'b1, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 32'h0000_0400, 32'h0000_0007, 1'b1, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h1234_5678};
    vecs[7] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h1234_5678};
    vecs[8] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    vecs[9] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};

    Reset2 = 1'b1; Reset0 = 1'b1;
    Req2 = 1'b0; Wr2 = 1'b0; Address2 = 32'h0; WriteData2 = 32'h0;
    Req0 = 1'b0; Wr0 = 1'b0; Address0 = 32'h0; WriteData0 = 32'h0;
    #12;
    check("rst_ready", {31'h0, Ready2}, 32'h0);
    check("rst_busy", {31'h0, Busy2}, 32'h0);
    check("rst_addrerr", {31'h0, AddrErr2}, 32'h0);
    check("rst_dataout", DataOut2, 32'h0);
    check("rst_dataout_lat0", DataOut0, 32'h0);
    Reset2 = 1'b0; Reset0 = 1'b0;
    @(posedge Clk); #1;
    check("idle_busy", {31'h0, Busy2}, 32'h0);

    // Table-driven transactions on the LATENCY=2 instance.
    for (int i = 0; i < 10; i++) begin
      run_txn(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, busy_n, err, data);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'd3);
      check($sformatf("v%0d_addrerr", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_dataout", i), data, vecs[i].exp_data);
    end

    // DataOut holds after a read response.
    run_txn(1'b0, 1'b0, 32'h10, 32'h0, lat, busy_n, err, data);
    check("hold_read", data, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      check($sformatf("hold_c%0d", k), DataOut2, 32'hDEAD_BEEF);
      check($sformatf("hold_ready_c%0d", k), {31'h0, Ready2}, 32'h0);
    end

    // Requests during WAIT and RESP are ignored; changed inputs after acceptance have no effect.
    Req2 = 1'b1; Wr2 = 1'b0; Address2 = 32'h20; WriteData2 = 32'h0;
    @(posedge Clk); #1;
    Req2 = 1'b1; Wr2 = 1'b1; Address2 = 32'h20; WriteData2 = 32'h0000_0BAD;
    @(posedge Clk); #1;
    Req2 = 1'b0;
    @(posedge Clk); #1;
    check("bw_ready", {31'h0, Ready2}, 32'h1);
    check("bw_dataout", DataOut2, 32'h1234_5678);
    Req2 = 1'b1;
    @(posedge Clk); #1;
    Req2 = 1'b0;
    check("bw_resp_req_ignored", {31'h0, Busy2}, 32'h0);
    run_txn(1'b0, 1'b0, 32'h20, 32'h0, lat, busy_n, err, data);
    check("bw_readback", data, 32'h1234_5678);

    // LATENCY=0 instance: preload, then two reads with Req held high.
    run_txn(1'b1, 1'b1, 32'h0, 32'h1111_1111, lat, busy_n, err, data);
    check("l0_wr0_latency", 32'(lat), 32'd1);
    run_txn(1'b1, 1'b1, 32'h4, 32'h2222_2222, lat, busy_n, err, data);
    check("l0_wr1_latency", 32'(lat), 32'd1);
    Req0 = 1'b1; Wr0 = 1'b0; Address0 = 32'h0;
    @(posedge Clk); #1;
    check("l0_rd0_ready", {31'h0, Ready0}, 32'h1);
    check("l0_rd0_data", DataOut0, 32'h1111_1111);
    Address0 = 32'h4;
    @(posedge Clk); #1;
    check("l0_gap_ready", {31'h0, Ready0}, 32'h0);
    check("l0_gap_busy", {31'h0, Busy0}, 32'h0);
    @(posedge Clk); #1;
    Req0 = 1'b0;
    check("l0_rd1_ready", {31'h0, Ready0}, 32'h1);
    check("l0_rd1_data", DataOut0, 32'h2222_2222);
    @(posedge Clk); #1;
    check("l0_end_busy", {31'h0, Busy0}, 32'h0);

    // Asynchronous reset in the middle of a write's WAIT.
    run_txn(1'b0, 1'b1, 32'h30, 32'h0, lat, busy_n, err, data);
    Req2 = 1'b1; Wr2 = 1'b1; Address2 = 32'h30; WriteData2 = 32'hA5A5_A5A5;
    @(posedge Clk); #1;
    Req2 = 1'b0;
    check("ar_busy_before", {31'h0, Busy2}, 32'h1);
    #2;
    Reset2 = 1'b1;
    #1;
    check("ar_busy", {31'h0, Busy2}, 32'h0);
    check("ar_ready", {31'h0, Ready2}, 32'h0);
    check("ar_addrerr", {31'h0, AddrErr2}, 32'h0);
    check("ar_dataout", DataOut2, 32'h0);
    @(posedge Clk); #1;
    Reset2 = 1'b0;
    @(posedge Clk); #1;
    run_txn(1'b0, 1'b0, 32'h30, 32'h0, lat, busy_n, err, data);
    check("ar_readback", data, 32'h0);
    check("ar_readback_latency", 32'(lat), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
